mem_bus_perf_monitor: RTL and testbench
=======================================

Name: mem_bus_perf_monitor

Overview:
- Synthesizable monitor on the native core memory interface (mem_valid/mem_ready/mem_instr/mem_addr/mem_wdata/mem_wstrb/mem_rdata), instantiated in riscv_top beside the core.
- Counts cycles, fetches, loads, stores and wait states, plus NCH configurable address-window hit counters.
- Detects program completion (store to DONE_ADDR) and a cycle-budget timeout, so both simulation and FPGA builds can report baseline vs. extension performance.
- Passive: never drives the bus.

Parameters:
- AW, 32, address width.
- CW, 32, width of every counter.
- NCH, 4, number of address-window channels (1..8).
- CH_BASE, {NCH{32'h0}}, packed NCH*AW channel base addresses; channel i uses bits [i*AW +: AW].
- CH_MASK, {NCH{32'h0}}, packed NCH*AW compare masks; a hit requires (mem_addr & mask) == (base & mask).
- DONE_ADDR, 32'h00000010, store address that signals completion.
- TIMEOUT_CYCLES, 30000000, RUN-cycle budget; 0 disables the timeout.
- TRACE_DEPTH, 8, trace entries (power of 2, at least 2); used only with MON_TRACE_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  IDLE->RUN request
- clear  in  1  synchronous soft clear to IDLE; all counters zeroed
- mem_valid  in  1  core request valid
- mem_instr  in  1  request is an instruction fetch
- mem_ready  in  1  memory response ready
- mem_addr  in  AW  request address
- mem_wdata  in  32  store data
- mem_wstrb  in  4  byte strobes; nonzero means store
- mem_rdata  in  32  read data (captured in trace only)
- state  out  2  0=IDLE 1=RUN 2=DONE 3=TIMEOUT
- done  out  1  high while state==DONE
- timeout  out  1  high while state==TIMEOUT
- done_data  out  32  wdata of the completion store
- cycle_count  out  CW  RUN cycles
- fetch_count  out  CW  completed fetches
- load_count  out  CW  completed data loads
- store_count  out  CW  completed stores
- wait_count  out  CW  cycles with mem_valid && !mem_ready
- chan_count  out  NCH*CW  per-channel completed-transfer hits
- trace_idx  in  log2(TRACE_DEPTH)  trace read index; 0 = most recent
- trace_pc  out  AW  fetch PC at trace_idx
- trace_instr  out  32  fetched instruction at trace_idx
- trace_fill  out  log2(TRACE_DEPTH)+1  number of valid trace entries

Behaviour:
- Transfer completes on any cycle with mem_valid && mem_ready (xfer).
- Classification of a completed transfer:
  - fetch = xfer && mem_instr
  - store = xfer && |mem_wstrb
  - load = xfer && !mem_instr && mem_wstrb==0
- Reset (rst=1 at posedge): state=IDLE; all counters, done_data, trace pointer and trace_fill = 0; done=timeout=0.
- clear has the same effect as rst and takes priority over every other event except rst.
- IDLE: counters hold. start=1 -> RUN on the next cycle. Bus activity during IDLE is ignored.
- RUN, every cycle:
  - cycle_count+1.
  - Fetch/load/store counters +1 on their class.
  - wait_count+1 when mem_valid && !mem_ready.
  - chan_count[i]+1 on xfer whose address matches channel i; several channels may hit on one transfer.
  - All counters saturate at all-ones; they never wrap.
- RUN -> DONE when store && mem_addr==DONE_ADDR.
  - done_data <= mem_wdata.
  - That cycle is still counted (cycle_count, store_count, channels).
- RUN -> TIMEOUT when TIMEOUT_CYCLES != 0 and cycle_count == TIMEOUT_CYCLES-1 at the edge, i.e. counted cycles reach TIMEOUT_CYCLES.
- Same-cycle completion store and timeout: DONE wins.
- DONE and TIMEOUT are terminal. All counters and done_data freeze. start is ignored; only clear or rst leaves them.
- start asserted while already in RUN: ignored.
- Latency: counters and state update one cycle after the qualifying bus cycle. All outputs are registered except trace_pc and trace_instr.
- A completion store with mem_valid high but mem_ready low does not complete the run; completion happens on the handshake cycle.

Optional Feature:
- MON_TRACE_EN defined:
  - TRACE_DEPTH circular buffer. Each fetch in RUN writes {mem_addr, mem_rdata} at the write pointer and advances it, wrapping at TRACE_DEPTH.
  - trace_fill increments and saturates at TRACE_DEPTH.
  - trace_pc/trace_instr are combinational reads of entry (wrptr-1-trace_idx) mod TRACE_DEPTH.
  - The buffer freezes in DONE/TIMEOUT for post-mortem inspection.
- Not defined: no storage; trace_pc, trace_instr and trace_fill are tied to 0; ports remain.

Test Plan:
- rst=1 for 5 cycles, then idle bus, start at cycle 10, 3 fetches with 0 wait states, then store to 0x10 with wdata=0xCAFEF00D -> state=DONE, done=1, fetch_count=3, store_count=1, done_data=0xCAFEF00D; counters frozen 20 cycles later.
- Fetch held with ready low for 4 cycles, then ready -> wait_count=4, fetch_count=1; a load to 0x2000 with 2 waits -> load_count=1, wait_count=6.
- TIMEOUT_CYCLES=100, start, no completion store -> timeout=1 with cycle_count=100; later store to 0x10 -> state stays TIMEOUT, store_count unchanged.
- CH_BASE0=0x1000/CH_MASK0=0xFFFFF000, CH_BASE1=0x1010/CH_MASK1=0xFFFFFFF0; load at 0x1014 -> chan0=1, chan1=1; load at 0x2000 -> no change.
- clear asserted mid-RUN on the same cycle as a completed store -> next cycle state=IDLE, all counters 0, store not counted; rst mid-DONE -> IDLE, done=0.
- MON_TRACE_EN, TRACE_DEPTH=8: 10 fetches at PC 0x0,0x4,...,0x24 -> trace_fill=8, trace_idx=0 gives 0x24, trace_idx=7 gives 0x08.

Source files
------------

// File: rtl/mem_bus_perf_monitor.sv
// rtl/mem_bus_perf_monitor.sv - passive performance monitor on the native core memory bus.
// Optional fetch trace buffer is built only when MON_TRACE_EN is defined.
module mem_bus_perf_monitor #(
  parameter int                 AW             = 32,
  parameter int                 CW             = 32,
  parameter int                 NCH            = 4,
  parameter logic [NCH*AW-1:0]  CH_BASE        = '0,
  parameter logic [NCH*AW-1:0]  CH_MASK        = '0,
  parameter logic [AW-1:0]      DONE_ADDR      = 'h10,
  parameter int unsigned        TIMEOUT_CYCLES = 30000000,
  parameter int                 TRACE_DEPTH    = 8,
  localparam int                TW             = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic              mem_valid,
  input  logic              mem_instr,
  input  logic              mem_ready,
  input  logic [AW-1:0]     mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  output logic [1:0]        state,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       done_data,
  output logic [CW-1:0]     cycle_count,
  output logic [CW-1:0]     fetch_count,
  output logic [CW-1:0]     load_count,
  output logic [CW-1:0]     store_count,
  output logic [CW-1:0]     wait_count,
  output logic [NCH*CW-1:0] chan_count,
  input  logic [TW-1:0]     trace_idx,
  output logic [AW-1:0]     trace_pc,
  output logic [31:0]       trace_instr,
  output logic [TW:0]       trace_fill
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  logic   xfer, is_fetch, is_store, is_load, run, done_hit, to_hit, wipe;

  assign xfer     = mem_valid && mem_ready;
  assign is_fetch = xfer && mem_instr;
  assign is_store = xfer && (|mem_wstrb);
  assign is_load  = xfer && !mem_instr && (mem_wstrb == 4'h0);
  assign run      = (state_q == S_RUN);
  assign done_hit = is_store && (mem_addr == DONE_ADDR);
  assign to_hit   = (TIMEOUT_CYCLES != 0) && (cycle_count == TO_LAST);
  assign wipe     = rst || clear;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (wipe) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Completion is checked before timeout so a same-cycle tie ends in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        if (done_hit)    state_d = S_DONE;
        else if (to_hit) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  assign state   = state_q;
  assign done    = (state_q == S_DONE);
  assign timeout = (state_q == S_TIMEOUT);

  always_ff @(posedge clk) begin
    if (wipe) begin
      cycle_count <= '0;
      fetch_count <= '0;
      load_count  <= '0;
      store_count <= '0;
      wait_count  <= '0;
      done_data   <= '0;
    end else if (run) begin
      cycle_count <= sat_inc(cycle_count);
      if (is_fetch)                 fetch_count <= sat_inc(fetch_count);
      if (is_load)                  load_count  <= sat_inc(load_count);
      if (is_store)                 store_count <= sat_inc(store_count);
      if (mem_valid && !mem_ready)  wait_count  <= sat_inc(wait_count);
      if (done_hit)                 done_data   <= mem_wdata;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic [AW-1:0] mask;
    logic [CW-1:0] cnt;
    logic          hit;
    assign mask = CH_MASK[i*AW +: AW];
    assign hit  = xfer && ((mem_addr & mask) == (CH_BASE[i*AW +: AW] & mask));
    always_ff @(posedge clk) begin
      if (wipe)            cnt <= '0;
      else if (run && hit) cnt <= sat_inc(cnt);
    end
    assign chan_count[i*CW +: CW] = cnt;
  end

`ifdef MON_TRACE_EN
  logic [AW+31:0] tbuf [TRACE_DEPTH];
  logic [TW-1:0]  wrptr, rdptr;
  logic [TW:0]    fill;

  always_ff @(posedge clk) begin
    if (wipe) begin
      wrptr <= '0;
      fill  <= '0;
    end else if (run && is_fetch) begin
      wrptr <= wrptr + 1'b1;
      if (fill != (TW+1)'(TRACE_DEPTH)) fill <= fill + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!wipe && run && is_fetch) tbuf[wrptr] <= {mem_addr, mem_rdata};
  end

  // Pointer arithmetic wraps at TRACE_DEPTH because TRACE_DEPTH is a power of two.
  assign rdptr       = wrptr - TW'(1) - trace_idx;
  assign trace_pc    = tbuf[rdptr][AW+31:32];
  assign trace_instr = tbuf[rdptr][31:0];
  assign trace_fill  = fill;
`else
  logic unused_trace;
  assign unused_trace = ^{mem_rdata, trace_idx};
  assign trace_pc     = '0;
  assign trace_instr  = '0;
  assign trace_fill   = '0;
`endif

endmodule

// File: tb/tb_mem_bus_perf_monitor.sv
// tb/tb_mem_bus_perf_monitor.sv - directed table-driven bench for mem_bus_perf_monitor.
// Trace checks follow MON_TRACE_EN; without it the trace outputs must read zero.
module tb_mem_bus_perf_monitor;

  logic         clk = 1'b0;
  logic         rst, start, clear;
  logic         mem_valid, mem_instr, mem_ready;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrb;
  logic [1:0]   state;
  logic         done, timeout;
  logic [31:0]  done_data, cycle_count, fetch_count, load_count, store_count, wait_count;
  logic [127:0] chan_count;
  logic [2:0]   trace_idx;
  logic [31:0]  trace_pc, trace_instr;
  logic [3:0]   trace_fill;

  int checks = 0;
  int failures = 0;

  mem_bus_perf_monitor #(
    .AW(32), .CW(32), .NCH(4),
    .CH_BASE({32'hFFFF0000, 32'h00002000, 32'h00001010, 32'h00001000}),
    .CH_MASK({32'hFFFF0000, 32'hFFFFFFFF, 32'hFFFFFFF0, 32'hFFFFF000}),
    .DONE_ADDR(32'h10), .TIMEOUT_CYCLES(100), .TRACE_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .state(state), .done(done), .timeout(timeout), .done_data(done_data),
    .cycle_count(cycle_count), .fetch_count(fetch_count), .load_count(load_count),
    .store_count(store_count), .wait_count(wait_count), .chan_count(chan_count),
    .trace_idx(trace_idx), .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_fill(trace_fill)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st, cl, v, ins, rdy;
    logic [31:0] a, wd;
    logic [3:0]  ws;
    logic [1:0]  es;
    logic [31:0] ec, ef, el, ess, ew;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic st, cl, v, ins, rdy, input logic [31:0] a, wd,
                              input logic [3:0] ws, input logic [1:0] es,
                              input int ec, ef, el, ess, ew);
    vec_t r;
    r.st = st; r.cl = cl; r.v = v; r.ins = ins; r.rdy = rdy;
    r.a = a; r.wd = wd; r.ws = ws; r.es = es;
    r.ec = ec; r.ef = ef; r.el = el; r.ess = ess; r.ew = ew;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic v, ins, rdy, input logic [31:0] a, wd, input logic [3:0] ws);
    mem_valid = v; mem_instr = ins; mem_ready = rdy;
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws; mem_rdata = 32'hA0000000 | a;
  endtask

  task automatic idle();
    start = 1'b0; clear = 1'b0;
    bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      start = tbl[i].st; clear = tbl[i].cl;
      bus(tbl[i].v, tbl[i].ins, tbl[i].rdy, tbl[i].a, tbl[i].wd, tbl[i].ws);
      tick();
      chk($sformatf("v%0d.state", i), state, tbl[i].es);
      chk($sformatf("v%0d.cycle", i), cycle_count, tbl[i].ec);
      chk($sformatf("v%0d.fetch", i), fetch_count, tbl[i].ef);
      chk($sformatf("v%0d.load", i), load_count, tbl[i].el);
      chk($sformatf("v%0d.store", i), store_count, tbl[i].ess);
      chk($sformatf("v%0d.wait", i), wait_count, tbl[i].ew);
    end
    idle();
  endtask

  initial begin
    // start cl  v  ins rdy addr          wdata         wstrb st  cyc f  l  s  w
    tbl[0]  = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 1, 32'h0,        32'h0,        4'h0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 1, 1, 1, 32'h0,        32'h0,        4'h0, 1, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 1, 32'h4,        32'h0,        4'h0, 1, 2, 2, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 1, 1, 32'h8,        32'h0,        4'h0, 1, 3, 3, 0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 0, 1, 32'h10,       32'hCAFEF00D, 4'hF, 2, 4, 3, 0, 1, 0);
    tbl[7]  = mk(0, 0, 1, 0, 1, 32'h10,       32'h12345678, 4'hF, 2, 4, 3, 0, 1, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 1, 0, 0, 0, 0, 0);
    tbl[10] = mk(0, 0, 1, 1, 0, 32'h100,      32'h0,        4'h0, 1, 1, 0, 0, 0, 1);
    tbl[11] = mk(0, 0, 1, 1, 0, 32'h100,      32'h0,        4'h0, 1, 2, 0, 0, 0, 2);
    tbl[12] = mk(0, 0, 1, 1, 0, 32'h100,      32'h0,        4'h0, 1, 3, 0, 0, 0, 3);
    tbl[13] = mk(0, 0, 1, 1, 0, 32'h100,      32'h0,        4'h0, 1, 4, 0, 0, 0, 4);
    tbl[14] = mk(0, 0, 1, 1, 1, 32'h100,      32'h0,        4'h0, 1, 5, 1, 0, 0, 4);
    tbl[15] = mk(0, 0, 1, 0, 0, 32'h2000,     32'h0,        4'h0, 1, 6, 1, 0, 0, 5);
    tbl[16] = mk(0, 0, 1, 0, 0, 32'h2000,     32'h0,        4'h0, 1, 7, 1, 0, 0, 6);
    tbl[17] = mk(0, 0, 1, 0, 1, 32'h2000,     32'h0,        4'h0, 1, 8, 1, 1, 0, 6);
    tbl[18] = mk(0, 0, 1, 0, 1, 32'h1014,     32'h0,        4'h0, 1, 9, 1, 2, 0, 6);
    tbl[19] = mk(0, 0, 1, 0, 1, 32'h2000,     32'h0,        4'h0, 1, 10, 1, 3, 0, 6);
    tbl[20] = mk(0, 0, 1, 0, 1, 32'h1008,     32'h55,       4'h3, 1, 11, 1, 3, 1, 6);
    tbl[21] = mk(0, 0, 1, 0, 0, 32'h10,       32'hDEAD,     4'hF, 1, 12, 1, 3, 1, 7);
    tbl[22] = mk(0, 1, 1, 0, 1, 32'h10,       32'hDEAD,     4'hF, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 32'h0,        32'h0,        4'h0, 0, 0, 0, 0, 0, 0);

    trace_idx = 3'd0;
    idle();
    rst = 1'b1;
    repeat (5) tick();
    rst = 1'b0;
    chk("rst.state", state, 2'd0);
    chk("rst.done", done, 1'b0);
    chk("rst.timeout", timeout, 1'b0);
    chk("rst.done_data", done_data, 32'h0);
    chk("rst.chan", chan_count, 128'h0);
    chk("rst.trace_fill", trace_fill, 4'h0);
    repeat (4) tick();

    run_vecs(0, 8);
    chk("done.flag", done, 1'b1);
    chk("done.data", done_data, 32'hCAFEF00D);
    bus(1'b1, 1'b1, 1'b1, 32'h1000, 32'h0, 4'h0);
    start = 1'b1;
    repeat (20) tick();
    idle();
    chk("frozen.state", state, 2'd2);
    chk("frozen.cycle", cycle_count, 32'd4);
    chk("frozen.fetch", fetch_count, 32'd3);
    chk("frozen.store", store_count, 32'd1);
    chk("frozen.chan", chan_count, 128'h0);
    chk("frozen.done_data", done_data, 32'hCAFEF00D);

    run_vecs(8, 22);
    chk("chan0", chan_count[31:0], 32'd2);
    chk("chan1", chan_count[63:32], 32'd1);
    chk("chan2", chan_count[95:64], 32'd2);
    chk("chan3", chan_count[127:96], 32'd0);
    chk("pend_store.done", done, 1'b0);
    run_vecs(22, 24);
    chk("clear.chan", chan_count, 128'h0);
    chk("clear.done_data", done_data, 32'h0);

    start = 1'b1; tick(); start = 1'b0;
    repeat (99) tick();
    chk("to.pre_state", state, 2'd1);
    chk("to.pre_cycle", cycle_count, 32'd99);
    tick();
    chk("to.state", state, 2'd3);
    chk("to.flag", timeout, 1'b1);
    chk("to.cycle", cycle_count, 32'd100);
    bus(1'b1, 1'b0, 1'b1, 32'h10, 32'h77, 4'hF);
    tick(); idle(); tick();
    chk("to.late_state", state, 2'd3);
    chk("to.late_store", store_count, 32'd0);
    chk("to.late_done", done, 1'b0);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("trace.fill_clr", trace_fill, 4'h0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus(1'b1, 1'b1, 1'b1, 32'(i * 4), 32'h0, 4'h0);
      tick();
    end
    idle();
    chk("trace.fetch", fetch_count, 32'd10);
`ifdef MON_TRACE_EN
    chk("trace.fill", trace_fill, 4'd8);
    trace_idx = 3'd0; #1;
    chk("trace.pc0", trace_pc, 32'h24);
    chk("trace.instr0", trace_instr, 32'hA0000024);
    trace_idx = 3'd7; #1;
    chk("trace.pc7", trace_pc, 32'h08);
    chk("trace.instr7", trace_instr, 32'hA0000008);
`else
    chk("trace.fill", trace_fill, 4'd0);
    trace_idx = 3'd0; #1;
    chk("trace.pc0", trace_pc, 32'h0);
    chk("trace.instr0", trace_instr, 32'h0);
`endif
    bus(1'b1, 1'b0, 1'b1, 32'h10, 32'hBEEF, 4'h1);
    tick();
    bus(1'b1, 1'b1, 1'b1, 32'h40, 32'h0, 4'h0);
    tick(); idle();
    chk("done2.state", state, 2'd2);
    chk("done2.data", done_data, 32'hBEEF);
    chk("done2.fetch_frozen", fetch_count, 32'd10);
`ifdef MON_TRACE_EN
    trace_idx = 3'd0; #1;
    chk("trace.frozen_pc0", trace_pc, 32'h24);
    chk("trace.frozen_fill", trace_fill, 4'd8);
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_done.state", state, 2'd0);
    chk("rst_done.done", done, 1'b0);
    chk("rst_done.cycle", cycle_count, 32'd0);
    chk("rst_done.data", done_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
